// File: rtl/counter_pkg.sv
// counter_pkg
// Shared definitions for the modulo up/down counter family.
//   CNT_UP / CNT_DOWN : direction encodings for the UP input
//   term_val()        : terminal value for a direction and modulus
//   clog2()           : bits needed to hold values 0..value-1
//   WRAPS_W/WRAPS_MAX : width and ceiling of the wrap counter
package counter_pkg;

    localparam logic CNT_UP   = 1'b1;
    localparam logic CNT_DOWN = 1'b0;

    localparam int unsigned    WRAPS_W   = 8;
    localparam logic [WRAPS_W-1:0] WRAPS_MAX = 8'hFF;

    // Counting up ends at modulus-1, counting down ends at 0.
    function automatic longint unsigned term_val(input logic up,
                                                 input longint unsigned modulus);
        if (up == CNT_DOWN) begin
            return 64'd0;
        end
        return modulus - 64'd1;
    endfunction

    // Number of bits needed to represent 0..value-1 (0 for value <= 1).
    function automatic int unsigned clog2(input longint unsigned value);
        longint unsigned v;
        int unsigned     n;
        v = (value == 64'd0) ? 64'd0 : value - 64'd1;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            if ((v >> i) != 64'd0) begin
                n = i + 1;
            end
        end
        return n;
    endfunction

endpackage

// File: rtl/counter_tc_detect.sv
// counter_tc_detect
// Combinational terminal-value compare for a modulo up/down counter.
//   count : current counter value (WIDTH bits)
//   up    : direction, 1 = counting up, 0 = counting down
//   tc    : high when count equals the terminal value for the direction
module counter_tc_detect
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH   = 4,
    parameter longint unsigned MODULUS = 16
) (
    input  logic [WIDTH-1:0] count,
    input  logic             up,
    output logic             tc
);

    localparam logic [WIDTH-1:0] TERM_UP   = WIDTH'(term_val(CNT_UP, MODULUS));
    localparam logic [WIDTH-1:0] TERM_DOWN = WIDTH'(term_val(CNT_DOWN, MODULUS));

    always_comb begin
        tc = (count == ((up == CNT_UP) ? TERM_UP : TERM_DOWN));
    end

endmodule

// File: rtl/counter_mod_updown.sv
// counter_mod_updown
// Modulo-MODULUS up/down counter with count enable, synchronous clamped load,
// optional saturation, cascadable carry/borrow and a saturating wrap counter.
//   CLK        : clock, rising edge
//   ASYNCRESET : asynchronous active-high reset (O = INIT, WRAPS = 0)
//   CE         : count enable
//   UP         : direction, 1 = up, 0 = down
//   LD         : synchronous load, overrides CE
//   D          : load value, clamped to MODULUS-1
//   O          : registered count
//   TC         : terminal count, combinational from O and UP
//   COUT       : TC & CE, drives CE of the next cascade stage
//   WRAPS      : registered wrap count, saturating at 255
module counter_mod_updown
    import counter_pkg::*;
#(
    parameter int unsigned     WIDTH    = 4,
    parameter longint unsigned MODULUS  = 16,
    parameter longint unsigned INIT     = 0,
    parameter bit              SATURATE = 1'b0
) (
    input  logic               CLK,
    input  logic               ASYNCRESET,
    input  logic               CE,
    input  logic               UP,
    input  logic               LD,
    input  logic [WIDTH-1:0]   D,
    output logic [WIDTH-1:0]   O,
    output logic               TC,
    output logic               COUT,
    output logic [WRAPS_W-1:0] WRAPS
);

    localparam longint unsigned SPAN       = 64'd1 << WIDTH;
    // With a full binary range the natural overflow is the wrap, no clamp needed.
    localparam bit              FULL_RANGE = (MODULUS == SPAN);
    localparam logic [WIDTH-1:0] MAX_VAL   = WIDTH'(MODULUS - 64'd1);
    localparam logic [WIDTH-1:0] INIT_VAL  = WIDTH'(INIT);
    localparam logic [WIDTH-1:0] ONE       = WIDTH'(1);

    // Parameter legality, evaluated at elaboration.
    if (WIDTH < 1 || WIDTH > 32) begin : gen_bad_width
        $error("counter_mod_updown: WIDTH must be 1..32");
    end
    if (MODULUS < 2 || MODULUS > SPAN) begin : gen_bad_modulus
        $error("counter_mod_updown: MODULUS must be 2..2**WIDTH");
    end
    if (clog2(MODULUS) > WIDTH) begin : gen_bad_clog2
        $error("counter_mod_updown: MODULUS does not fit in WIDTH bits");
    end
    if (INIT >= MODULUS) begin : gen_bad_init
        $error("counter_mod_updown: INIT must be below MODULUS");
    end

    logic [WIDTH-1:0]   count_q, count_d;
    logic [WRAPS_W-1:0] wraps_q, wraps_d;
    logic               tc;
    logic [WIDTH-1:0]   inc, dec, load_val, wrap_val;

    counter_tc_detect #(
        .WIDTH   (WIDTH),
        .MODULUS (MODULUS)
    ) u_tc_detect (
        .count (count_q),
        .up    (UP),
        .tc    (tc)
    );

    always_comb begin
        inc = count_q + ONE;
        dec = count_q - ONE;

        // Out-of-range loads clamp to the top of the range.
        if (FULL_RANGE || (D <= MAX_VAL)) begin
            load_val = D;
        end else begin
            load_val = MAX_VAL;
        end

        if (FULL_RANGE) begin
            wrap_val = (UP == CNT_UP) ? inc : dec;
        end else begin
            wrap_val = (UP == CNT_UP) ? '0 : MAX_VAL;
        end
    end

    always_comb begin
        count_d = count_q;
        wraps_d = wraps_q;
        if (LD) begin
            count_d = load_val;
        end else if (CE) begin
            if (!tc) begin
                count_d = (UP == CNT_UP) ? inc : dec;
            end else if (!SATURATE) begin
                count_d = wrap_val;
                if (wraps_q != WRAPS_MAX) begin
                    wraps_d = wraps_q + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge CLK or posedge ASYNCRESET) begin
        if (ASYNCRESET) begin
            count_q <= INIT_VAL;
            wraps_q <= '0;
        end else begin
            count_q <= count_d;
            wraps_q <= wraps_d;
        end
    end

    assign O     = count_q;
    assign TC    = tc;
    assign COUT  = tc & CE;
    assign WRAPS = wraps_q;

endmodule

// File: doc/counter_mod_updown.md
# counter_mod_updown

Parametrised successor of the fixed 4-bit free-running counter with carry-out. Counts up or down modulo a programmable modulus, with count-enable, synchronous parallel load, optional saturation and a cascadable carry/borrow output. Used as the general-purpose counter primitive for dividers, timers and multi-digit cascades in the same test and fault-injection flow.

## Interface
- `WIDTH`, 4: counter width in bits, 1..32.
- `MODULUS`, 16: count range 0..MODULUS-1. Must satisfy 2 ≤ MODULUS ≤ 2^WIDTH.
- `INIT`, 0: value taken on reset. Must satisfy INIT < MODULUS.
- `SATURATE`, 0: 0 means wrap at the terminal value; 1 means hold at the terminal value.

- `CLK`, in, 1: clock, rising edge.
- `ASYNCRESET`, in, 1: asynchronous, active-high reset.
- `CE`, in, 1: count enable.
- `UP`, in, 1: direction. 1 counts up, 0 counts down.
- `LD`, in, 1: synchronous load.
- `D`, in, WIDTH: load value.
- `O`, out, WIDTH: registered count.
- `TC`, out, 1: terminal count flag, combinational from O and UP.
- `COUT`, out, 1: carry/borrow, combinational, equal to TC & CE.
- `WRAPS`, out, 8: registered wrap counter, saturating at 255.

## Operation
- Terminal value is MODULUS-1 when UP=1 and 0 when UP=0. TC=1 when O equals the terminal value.
- Priority at each rising edge: ASYNCRESET, then LD, then CE, then hold.
- **LD=1:** O ← D if D < MODULUS, otherwise O ← MODULUS-1 (clamped). WRAPS is unchanged. LD overrides CE.
- **CE=1, LD=0, TC=0:** O ← O+1 when UP=1, O ← O−1 when UP=0.
- **CE=1, LD=0, TC=1, SATURATE=0:** O ← 0 when UP=1, O ← MODULUS-1 when UP=0. WRAPS increments, saturating at 255.
- **CE=1, LD=0, TC=1, SATURATE=1:** O holds. WRAPS unchanged.
- **CE=0, LD=0:** O and WRAPS hold.
- Arithmetic is WIDTH bits. When MODULUS = 2^WIDTH, wrap is natural overflow and no compare is needed. No intermediate value ever leaves the range [0, MODULUS-1].
- UP may change on any cycle. TC and COUT follow UP combinationally within the same cycle.
- Cascading: connect COUT of stage n to CE of stage n+1. All stages share CLK, ASYNCRESET and UP.

## Timing
- Reset values: O = INIT, WRAPS = 0. TC and COUT are derived from these (COUT = 0 while CE = 0).
- Asserting ASYNCRESET forces O and WRAPS immediately, without waiting for a clock edge.
- Deasserting ASYNCRESET: the first count occurs at the first rising edge after deassertion.
- Reset mid-count discards any pending load or count.
- Count latency is 1 cycle. O updates after the rising edge at which CE was sampled high.
- Load latency is 1 cycle.
- Sampling convention: a monitor that samples O in the same timestep as the rising edge sees the pre-edge value. Period-10 benches check on that edge.
- COUT has no register stage. An N-stage cascade adds N compare+AND levels to the critical path.

## Structure
- Shared package `counter_pkg`:
  - direction constants `CNT_UP = 1'b1`, `CNT_DOWN = 1'b0`
  - function `term_val(up, modulus)`
  - width check `clog2` helper
- One sub-module `counter_tc_detect`: combinational terminal-value compare, parametrised on WIDTH and MODULUS. Outputs TC. Reused by the timer block.
- Parameter legality is checked by elaboration-time assertions on MODULUS range and INIT < MODULUS.

## Test plan
1. **Default parameters, reset.** Release reset with CE=1, UP=1 and sample on each rising edge, period 10. Required: O = 0, 1, 2, 3, 4, 5, 6 on successive edges. COUT = 0 throughout. COUT = 1 only while O = 15.
2. **WIDTH=4, MODULUS=10, count up.** Run 12 enabled cycles from 0. Required: O goes 0…9, 0, 1. COUT is high exactly in the cycle O = 9. WRAPS = 1.
3. **Down count and direction change.** INIT=2, UP=0, CE=1. Required: O goes 2, 1, 0, 9 (MODULUS=10). COUT is high when O = 0. Then set UP=1 with O=9. Required: TC=1 in the same cycle, and the next edge gives O = 0.
4. **Load priority and clamping.** Assert LD=1 and CE=1 with D=7. Required: O = 7 next cycle, no increment. Then load D=12 with MODULUS=10. Required: O = 9.
5. **Saturation.** SATURATE=1, MODULUS=16, count up from 13. Required: O goes 13, 14, 15, 15, 15. WRAPS stays 0.
6. **Asynchronous reset and cascade.** Assert ASYNCRESET mid-cycle at O=5. Required: O = INIT before the next edge. Then run two cascaded stages (MODULUS=10) for 25 enabled cycles. Required: {hi, lo} = {2, 5}.
